// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and port index constants for the data-memory
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic port_t;

    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Two requester ports plus the data-memory port of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [31:0]      addr0;
    logic [31:0]      addr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic             mem_write_en;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_write_data;
    logic [WIDTH-1:0] mem_read_data;

    // Requesters plus the memory model
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_write_en, mem_addr, mem_write_data,
        output mem_read_data
    );

    // The arbiter itself
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_write_en, mem_addr, mem_write_data,
        input  mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin winner selection.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last,
    output port_t winner,
    output logic  any
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            winner = (last == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter in front of a single data memory,
//               one access per two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_t           r_state;
    state_t           w_next_state;
    port_t            r_last;
    port_t            r_win;
    port_t            w_win;
    logic             w_any;
    logic             w_access;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;
    logic             r_rvalid0;
    logic             r_rvalid1;

    rr_arb2 u_rr_arb2 (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (r_last),
        .winner (w_win),
        .any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = ACCESS;
            ACCESS:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // rst gates the access combinationally so an aborted cycle never writes or grants
    always_comb begin
        w_access           = (r_state == ACCESS) && !rst;
        bus.gnt0           = w_access && (r_win == PORT0);
        bus.gnt1           = w_access && (r_win == PORT1);
        bus.mem_write_en   = w_access && r_we;
        bus.mem_addr       = r_addr;
        bus.mem_write_data = r_wdata;
        bus.rvalid0        = r_rvalid0;
        bus.rvalid1        = r_rvalid1;
        bus.rdata0         = r_rdata0;
        bus.rdata1         = r_rdata1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= PORT1;
            r_win     <= PORT0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if ((r_state == IDLE) && w_any) begin
                r_win   <= w_win;
                r_we    <= (w_win == PORT1) ? bus.we1    : bus.we0;
                r_addr  <= (w_win == PORT1) ? bus.addr1  : bus.addr0;
                r_wdata <= (w_win == PORT1) ? bus.wdata1 : bus.wdata0;
            end
            if (r_state == ACCESS) begin
                r_last <= r_win;
                if (!r_we) begin
                    if (r_win == PORT0) begin
                        r_rdata0  <= bus.mem_read_data;
                        r_rvalid0 <= 1'b1;
                    end else begin
                        r_rdata1  <= bus.mem_read_data;
                        r_rvalid1 <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a 256-word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0]      addr;
        logic             we;
        logic [WIDTH-1:0] wd;
        int               cyc;
    } gexp_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(WIDTH)) bus ();

    dmem_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word-addressed memory, initial contents 0xA5000000 | index
    logic [WIDTH-1:0] mem [256];
    logic             mem_init_done = 1'b0;
    assign bus.mem_read_data = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= WIDTH'(32'hA500_0000 | i);
            mem_init_done <= 1'b1;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_write_data;
        end
    end

    gexp_t            gq0[$];
    gexp_t            gq1[$];
    rexp_t            rq0[$];
    rexp_t            rq1[$];
    int               gl_port[$];
    int               gl_cyc[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    logic             rst_q = 1'b1;
    logic [WIDTH-1:0] hold0 = '0;
    logic [WIDTH-1:0] hold1 = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_gnt(input int p);
        gexp_t e;
        total++;
        if ((p == 0 && gq0.size() == 0) || (p == 1 && gq1.size() == 0)) begin
            bad++;
            $display("FAIL gnt%0d_unexpected: got gnt at cycle %0d want none", p, cyc);
        end else begin
            e = (p == 0) ? gq0.pop_front() : gq1.pop_front();
            if (bus.mem_addr !== e.addr || bus.mem_write_en !== e.we ||
                (e.we && bus.mem_write_data !== e.wd) || (e.cyc >= 0 && cyc != e.cyc)) begin
                bad++;
                $display("FAIL gnt%0d: got addr=%h we=%b wd=%h cyc=%0d want addr=%h we=%b wd=%h cyc=%0d",
                         p, bus.mem_addr, bus.mem_write_en, bus.mem_write_data, cyc,
                         e.addr, e.we, e.wd, e.cyc);
            end
        end
        gl_port.push_back(p);
        gl_cyc.push_back(cyc);
    endtask

    task automatic chk_rv(input int p, input logic [WIDTH-1:0] got, output logic [WIDTH-1:0] hold);
        rexp_t e;
        total++;
        if ((p == 0 && rq0.size() == 0) || (p == 1 && rq1.size() == 0)) begin
            bad++;
            hold = got;
            $display("FAIL rvalid%0d_unexpected: got rvalid at cycle %0d want none", p, cyc);
        end else begin
            e = (p == 0) ? rq0.pop_front() : rq1.pop_front();
            hold = e.data;
            if (got !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
                bad++;
                $display("FAIL rvalid%0d: got rdata=%h cyc=%0d want rdata=%h cyc=%0d",
                         p, got, cyc, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, pops expectations as the DUT responds
    always @(negedge clk) begin
        chk("gnt_exclusive", 64'(bus.gnt0 & bus.gnt1), 64'd0);
        chk("rvalid_exclusive", 64'(bus.rvalid0 & bus.rvalid1), 64'd0);
        chk("wen_outside_access", 64'(bus.mem_write_en & ~(bus.gnt0 | bus.gnt1)), 64'd0);
        if (bus.gnt0) chk_gnt(0);
        if (bus.gnt1) chk_gnt(1);
        if (rst_q) begin
            hold0 = '0;
            hold1 = '0;
        end
        if (bus.rvalid0) chk_rv(0, bus.rdata0, hold0);
        else             chk("rdata0_hold", 64'(bus.rdata0), 64'(hold0));
        if (bus.rvalid1) chk_rv(1, bus.rdata1, hold1);
        else             chk("rdata1_hold", 64'(bus.rdata1), 64'(hold1));
    end

    task automatic acc(input int p, input logic we, input logic [31:0] a,
                       input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_rd,
                       input int gcyc, input int rcyc);
        gexp_t g;
        rexp_t r;
        logic  got;
        g.addr = a; g.we = we; g.wd = d; g.cyc = gcyc;
        r.data = exp_rd; r.cyc = rcyc;
        if (p == 0) begin
            gq0.push_back(g);
            if (!we) rq0.push_back(r);
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            gq1.push_back(g);
            if (!we) rq1.push_back(r);
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? bus.gnt0 : bus.gnt1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL acc_timeout: port%0d got no gnt want gnt within 40 cycles", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctrl"}, 64'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_write_en}), 64'd0);
        chk({nm, "_rdata0"}, 64'(bus.rdata0), 64'd0);
        chk({nm, "_rdata1"}, 64'(bus.rdata1), 64'd0);
        chk({nm, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({nm, "_mem_wdata"}, 64'(bus.mem_write_data), 64'd0);
    endtask

    function automatic int count_port(input int p);
        int n = 0;
        foreach (gl_port[i]) if (gl_port[i] == p) n++;
        return n;
    endfunction

    initial begin
        int base;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Simultaneous reads straight out of reset: port 0 first
        @(posedge clk);
        #1;
        base = cyc;
        rst  = 1'b0;
        fork
            acc(0, 1'b0, 32'h00, '0, 32'hA500_0000, base + 1, base + 2);
            acc(1, 1'b0, 32'h04, '0, 32'hA500_0001, base + 3, base + 4);
        join

        // Write then read back on port 0
        gl_port.delete(); gl_cyc.delete();
        acc(0, 1'b1, 32'h10, 32'hDEAD_BEEF, '0, -1, -1);
        acc(0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, -1, -1);
        repeat (3) @(negedge clk);
        chk("wr_rd_gnt0_count", 64'(count_port(0)), 64'd2);
        chk("wr_rd_gnt1_count", 64'(count_port(1)), 64'd0);

        // Continuous contention from a fresh reset
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        gl_port.delete(); gl_cyc.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    acc(0, 1'b0, 32'h80 + 32'(4 * i), '0, 32'hA500_0020 + 32'(i), -1, -1);
            end
            begin
                for (int j = 0; j < 8; j++)
                    acc(1, 1'b0, 32'hC0 + 32'(4 * j), '0, 32'hA500_0030 + 32'(j), -1, -1);
            end
        join
        repeat (3) @(negedge clk);
        chk("contention_count", 64'(gl_port.size()), 64'd16);
        if (gl_port.size() == 16) begin
            for (int k = 0; k < 16; k++) chk("contention_order", 64'(gl_port[k]), 64'(k % 2));
            chk("contention_span", 64'(gl_cyc[15] - gl_cyc[0]), 64'd30);
        end

        // Reset lands in port 1's write access
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20; bus.wdata1 = 32'h0000_1234;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_gnt1", 64'(bus.gnt1), 64'd0);
        chk("abort_wen", 64'(bus.mem_write_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        @(negedge clk);
        check_all_zero("abort_after");
        chk("abort_mem8", 64'(mem[8]), 64'hA500_0008);

        // Unaligned read passes the address through untouched
        acc(1, 1'b0, 32'h23, '0, 32'hA500_0008, -1, -1);

        // Port 1 streaming alone
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        gl_port.delete(); gl_cyc.delete();
        for (int i = 0; i < 4; i++)
            acc(1, 1'b0, 32'h30 + 32'(4 * i), '0, 32'hA500_000C + 32'(i), -1, -1);
        repeat (3) @(negedge clk);
        chk("stream_count", 64'(count_port(1)), 64'd4);
        if (gl_cyc.size() == 4) begin
            for (int k = 1; k < 4; k++) chk("stream_interval", 64'(gl_cyc[k] - gl_cyc[k-1]), 64'd2);
        end

        repeat (3) @(negedge clk);
        chk("left_gq0", 64'(gq0.size()), 64'd0);
        chk("left_gq1", 64'(gq1.size()), 64'd0);
        chk("left_rq0", 64'(rq0.size()), 64'd0);
        chk("left_rq1", 64'(rq1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of both requester ports and the memory port, SHALL be provided.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0/req1  input  1 each  access request, port 0 / port 1.
REQ-005 we0/we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0/addr1  input  32 each  byte address.
REQ-007 wdata0/wdata1  input  WIDTH each  write data.
REQ-008 gnt0/gnt1  output  1 each  one-cycle pulse; request consumed.
REQ-009 rvalid0/rvalid1  output  1 each  one-cycle pulse; read data valid.
REQ-010 rdata0/rdata1  output  WIDTH each  read data, held until the next read completes on that port.
REQ-011 mem_write_en  output  1  write enable to the data memory.
REQ-012 mem_addr  output  32  byte address to the data memory, bits [1:0] passed through unchanged.
REQ-013 mem_write_data  output  WIDTH  write data to the data memory.
REQ-014 mem_read_data  input  WIDTH  combinational read data from the data memory.

Function
REQ-015 The FSM SHALL have two states, IDLE and ACCESS.
REQ-016 IDLE, no req: stay in IDLE; mem_write_en = 0.
REQ-017 IDLE, any req at an edge: latch winner index, we, addr and wdata into registers; go to ACCESS.
REQ-018 Both req in IDLE: winner = port not served last (round-robin); one req: that port wins.
REQ-019 ACCESS: drive mem_addr/mem_write_data from latches; mem_write_en = latched we; assert gnt of winner only; next state IDLE unconditionally.
REQ-020 Requester SHALL hold req/we/addr/wdata stable until the edge where its gnt is high; the arbiter SHALL ignore input changes after latching.
REQ-021 Read in ACCESS: capture mem_read_data into winner's rdata at the ACCESS-ending edge; rvalid of winner high the following cycle only.
REQ-022 Write: no rvalid; rdata unchanged.
REQ-023 Latency: req sampled at edge T -> gnt in cycle T+1 -> rvalid/rdata in cycle T+2; throughput 1 access per 2 cycles.
REQ-024 Last-served pointer SHALL update to the winner at the ACCESS-ending edge.
REQ-025 A port holding req continuously SHALL wait at most one access of the other port (no starvation).
REQ-026 Outputs mem_addr/mem_write_data in IDLE SHALL hold last latched values; mem_write_en SHALL be 0 outside ACCESS.
REQ-027 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 SHALL never be high together.
REQ-028 No alignment or range checks SHALL be performed; addresses SHALL pass through unmodified.

Reset
REQ-029 rst high at an edge: state IDLE; gnt0/1, rvalid0/1, mem_write_en = 0; rdata0/1, mem_addr, mem_write_data, latches = 0; last-served = port 1, so port 0 wins first.
REQ-030 rst during ACCESS SHALL abort the access: no write at that edge, no gnt and no rvalid afterwards.
REQ-031 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the state enum (IDLE, ACCESS) and the port index constants PORT0 = 0 and PORT1 = 1.
REQ-033 Winner selection SHALL be a combinational sub-module rr_arb2 (inputs req0, req1, last; output winner, any).
REQ-034 The data memory SHALL be instantiated outside this block; the bench SHALL connect a word-addressed 256-entry memory model.

Verification
REQ-035 Write then read, port 0: write 0xDEADBEEF to 0x10, then read 0x10 -> gnt0 pulses twice, rvalid0 once, rdata0 = 0xDEADBEEF; rvalid1 never high.
REQ-036 Simultaneous reads from reset: req0 to 0x00 and req1 to 0x04, both held -> gnt0 in cycle 2, gnt1 in cycle 4, rvalid0 in cycle 3, rvalid1 in cycle 5.
REQ-037 Continuous contention: both ports request 8 times each -> grants alternate 0,1,0,1,...; 16 grants in 32 cycles.
REQ-038 Reset mid-access: port 1 write 0x1234 to 0x20, rst asserted in its ACCESS cycle -> memory[8] unchanged, no gnt1, all outputs 0 next cycle.
REQ-039 Unaligned address: port 1 read at 0x23 -> mem_addr = 0x23, rdata1 = memory[8].
REQ-040 Single requester streaming: port 1 issues back-to-back reads -> gnt1 every 2 cycles; rdata1 holds between rvalid1 pulses.
